// File: rtl/rtc_osd_overlay_pkg.sv
// Shared definitions for the RTC on-screen-display overlay.
// Holds the glyph code constants, the font cell geometry and the helper that
// turns a BCD nibble into a glyph code.
package rtc_osd_overlay_pkg;

  localparam int GLYPH_W    = 8;   // font cell width in pixels
  localparam int GLYPH_H    = 16;  // font cell height in lines
  localparam int TEXT_CHARS = 8;   // "HH:MM:SS"

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;

  // Digits map to their own code; anything that is not valid BCD shows blank.
  function automatic logic [3:0] bcd_to_glyph(input logic [3:0] nibble);
    return (nibble > 4'd9) ? GLYPH_BLANK : nibble;
  endfunction

endpackage

// File: rtl/rtc_osd_overlay_if.sv
// Video stream bundle for the OSD overlay.
// i_* : incoming syncs, data-enable and RGB888 pixel from the timing source.
// o_* : the same stream after the overlay, towards the encoder.
// master : the side that sources i_* and observes o_* (source / testbench).
// slave  : the overlay itself.
interface rtc_osd_overlay_if;
  logic        i_hs;
  logic        i_vs;
  logic        i_de;
  logic [23:0] i_data;
  logic        o_hs;
  logic        o_vs;
  logic        o_de;
  logic [23:0] o_data;

  modport master (
    output i_hs, i_vs, i_de, i_data,
    input  o_hs, o_vs, o_de, o_data
  );

  modport slave (
    input  i_hs, i_vs, i_de, i_data,
    output o_hs, o_vs, o_de, o_data
  );
endinterface

// File: rtl/rtc_osd_overlay_font_rom.sv
// osd_font_rom: 8x16 bitmaps of '0'-'9' and ':' from the IBM VGA ROM font.
// glyph : glyph code (0-9 digits, 10 colon, 11 and above blank)
// row   : line within the cell, 0 = top
// bits  : row byte, bit 7 = leftmost column
module osd_font_rom
  import rtc_osd_overlay_pkg::*;
(
  input  logic [3:0] glyph,
  input  logic [3:0] row,
  output logic [7:0] bits
);

  // Each glyph is packed as 16 row bytes, row 0 in the top byte.
  logic [127:0] glyph_rows;

  always_comb begin
    glyph_rows = '0;
    case (glyph)
      4'd0:        glyph_rows = 128'h00007cc6c6cedef6e6c6c67c00000000;
      4'd1:        glyph_rows = 128'h00001838781818181818187e00000000;
      4'd2:        glyph_rows = 128'h00007cc6060c183060c0c6fe00000000;
      4'd3:        glyph_rows = 128'h00007cc606063c060606c67c00000000;
      4'd4:        glyph_rows = 128'h00000c1c3c6cccfe0c0c0c1e00000000;
      4'd5:        glyph_rows = 128'h0000fec0c0c0fc060606c67c00000000;
      4'd6:        glyph_rows = 128'h00003860c0c0fcc6c6c6c67c00000000;
      4'd7:        glyph_rows = 128'h0000fec606060c183030303000000000;
      4'd8:        glyph_rows = 128'h00007cc6c6c67cc6c6c6c67c00000000;
      4'd9:        glyph_rows = 128'h00007cc6c6c67e0606060c7800000000;
      GLYPH_COLON: glyph_rows = 128'h00000000181800000018180000000000;
      default:     glyph_rows = '0;
    endcase
    // Row r sits at bit offset (15-r)*8; for a 4-bit row, 15-r is ~row.
    bits = glyph_rows[{~row, 3'b000} +: 8];
  end

endmodule

// File: rtl/rtc_osd_overlay.sv
// rtc_osd_overlay: draws the RTC time as "HH:MM:SS" over an RGB888 stream.
// pclk     : pixel clock, all logic on the rising edge
// rst_n    : asynchronous active-low reset, released synchronously to pclk
// rtc_data : BCD {hour, minute, second}, sampled once per frame on the
//            active vsync edge
// vid      : video bundle; o_* are i_* delayed by exactly two pclk cycles,
//            with glyph foreground pixels inside the text window replaced
//            by FG_COLOR
module rtc_osd_overlay
  import rtc_osd_overlay_pkg::*;
#(
  parameter int unsigned OSD_X      = 9,
  parameter int unsigned OSD_Y      = 9,
  parameter int unsigned SCALE_LOG2 = 1,
  parameter logic [23:0] FG_COLOR   = 24'hFF0000,
  parameter logic        VS_POL     = 1'b1
) (
  input  logic           pclk,
  input  logic           rst_n,
  input  logic [23:0]    rtc_data,
  rtc_osd_overlay_if.slave vid
);

  localparam logic [12:0] WIN_X0 = 13'(OSD_X);
  localparam logic [12:0] WIN_Y0 = 13'(OSD_Y);
  localparam logic [12:0] WIN_W  = 13'((TEXT_CHARS * GLYPH_W) << SCALE_LOG2);
  localparam logic [12:0] WIN_H  = 13'(GLYPH_H << SCALE_LOG2);

  // position tracking and frame-stable time
  logic [11:0] x_reg, y_reg;
  logic        de_prev_reg, vs_prev_reg;
  logic [23:0] time_reg;

  // stage 1
  logic        s1_hs_reg, s1_vs_reg, s1_de_reg, s1_win_reg;
  logic [23:0] s1_data_reg;
  logic [3:0]  s1_glyph_reg, s1_row_reg;
  logic [2:0]  s1_col_reg;

  // stage 2 / outputs
  logic        o_hs_reg, o_vs_reg, o_de_reg;
  logic [23:0] o_data_reg;

  logic        vs_edge, de_fall, in_win;
  logic [12:0] dx, dy;
  logic [2:0]  char_idx, col;
  logic [3:0]  row, glyph;
  logic [7:0]  font_bits;

  always_comb begin
    vs_edge = (vid.i_vs == VS_POL) && (vs_prev_reg != VS_POL);
    de_fall = de_prev_reg && !vid.i_de;
    // One extra bit keeps the borrow, so a pixel left of / above the window
    // lands far above WIN_W / WIN_H instead of wrapping into it.
    dx       = {1'b0, x_reg} - WIN_X0;
    dy       = {1'b0, y_reg} - WIN_Y0;
    in_win   = vid.i_de && (dx < WIN_W) && (dy < WIN_H);
    char_idx = dx[SCALE_LOG2 + 3 +: 3];
    col      = dx[SCALE_LOG2 +: 3];
    row      = dy[SCALE_LOG2 +: 4];
    glyph    = GLYPH_COLON;
    case (char_idx)
      3'd0:    glyph = bcd_to_glyph(time_reg[23:20]);
      3'd1:    glyph = bcd_to_glyph(time_reg[19:16]);
      3'd3:    glyph = bcd_to_glyph(time_reg[15:12]);
      3'd4:    glyph = bcd_to_glyph(time_reg[11:8]);
      3'd6:    glyph = bcd_to_glyph(time_reg[7:4]);
      3'd7:    glyph = bcd_to_glyph(time_reg[3:0]);
      default: glyph = GLYPH_COLON;
    endcase
  end

  osd_font_rom u_font_rom (
    .glyph (s1_glyph_reg),
    .row   (s1_row_reg),
    .bits  (font_bits)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg        <= '0;
      y_reg        <= '0;
      de_prev_reg  <= 1'b0;
      vs_prev_reg  <= 1'b0;
      time_reg     <= '0;
      s1_hs_reg    <= 1'b0;
      s1_vs_reg    <= 1'b0;
      s1_de_reg    <= 1'b0;
      s1_win_reg   <= 1'b0;
      s1_data_reg  <= '0;
      s1_glyph_reg <= '0;
      s1_row_reg   <= '0;
      s1_col_reg   <= '0;
      o_hs_reg     <= 1'b0;
      o_vs_reg     <= 1'b0;
      o_de_reg     <= 1'b0;
      o_data_reg   <= '0;
    end else begin
      // x is the index of the current active pixel, so it restarts at 0
      // whenever data-enable is low.
      x_reg       <= vid.i_de ? x_reg + 12'd1 : '0;
      de_prev_reg <= vid.i_de;
      vs_prev_reg <= vid.i_vs;
      if (vs_edge) begin
        y_reg    <= '0;
        time_reg <= rtc_data;
      end else if (de_fall) begin
        y_reg <= y_reg + 12'd1;
      end

      s1_hs_reg    <= vid.i_hs;
      s1_vs_reg    <= vid.i_vs;
      s1_de_reg    <= vid.i_de;
      s1_data_reg  <= vid.i_data;
      s1_win_reg   <= in_win;
      s1_glyph_reg <= glyph;
      s1_row_reg   <= row;
      s1_col_reg   <= col;

      o_hs_reg   <= s1_hs_reg;
      o_vs_reg   <= s1_vs_reg;
      o_de_reg   <= s1_de_reg;
      // Column c is bit 7-c of the row byte; for 3 bits that is ~c.
      o_data_reg <= (s1_win_reg && font_bits[~s1_col_reg]) ? FG_COLOR : s1_data_reg;
    end
  end

  assign vid.o_hs   = o_hs_reg;
  assign vid.o_vs   = o_vs_reg;
  assign vid.o_de   = o_de_reg;
  assign vid.o_data = o_data_reg;

endmodule

// File: tb/tb_rtc_osd_overlay.sv
// Testbench for rtc_osd_overlay. Two instances share one stimulus stream:
// dut_a uses the default window, dut_b the unscaled window at the origin.
// Expected outputs are queued when each pixel is issued; a monitor on the
// falling edge pops and compares them two cycles later.
module tb_rtc_osd_overlay;

  localparam int H_ACT = 140;
  localparam int H_TOT = 148;
  localparam int V_TOT = 44;   // line 0 vsync, line 1 blank, lines 2..43 active

  typedef struct {
    int          stamp;
    logic        hs, vs, de;
    logic [23:0] da, db;
    bit          chk;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] rtc = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          frame_no = 0;
  exp_t        q[$];
  logic [127:0] font_tb [11];
  logic [23:0] bars [8];
  logic [23:0] shadow = '0;
  logic        prev_vs_tb = 1'b0;

  rtc_osd_overlay_if vif_a ();
  rtc_osd_overlay_if vif_b ();

  rtc_osd_overlay dut_a (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .rtc_data (rtc),
    .vid      (vif_a)
  );

  rtc_osd_overlay #(.OSD_X(0), .OSD_Y(0), .SCALE_LOG2(0)) dut_b (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .rtc_data (rtc),
    .vid      (vif_b)
  );

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  function automatic logic hit(input int x, input int y, input logic [23:0] t,
                               input int s, input int ox, input int oy);
    int lx, ly, ci, col, row, g;
    logic [3:0] nib;
    lx = x - ox;
    ly = y - oy;
    if (lx < 0 || ly < 0 || lx >= (64 << s) || ly >= (16 << s)) return 1'b0;
    ci  = lx >> (3 + s);
    col = (lx >> s) & 7;
    row = ly >> s;
    case (ci)
      0: nib = t[23:20];
      1: nib = t[19:16];
      3: nib = t[15:12];
      4: nib = t[11:8];
      6: nib = t[7:4];
      7: nib = t[3:0];
      default: nib = 4'd10;
    endcase
    g = (ci == 2 || ci == 5) ? 10 : ((nib > 4'd9) ? 11 : int'(nib));
    if (g == 11) return 1'b0;
    return font_tb[g][127 - row * 8 - col];
  endfunction

  // Drive one pixel into both instances, queue what should come out.
  task automatic pix(input logic hs, input logic vs, input logic de,
                     input logic [23:0] data, input int x, input int y, input bit chk);
    exp_t e;
    vif_a.i_hs = hs; vif_a.i_vs = vs; vif_a.i_de = de; vif_a.i_data = data;
    vif_b.i_hs = hs; vif_b.i_vs = vs; vif_b.i_de = de; vif_b.i_data = data;
    if (vs && !prev_vs_tb) shadow = rtc;
    prev_vs_tb = vs;
    e.stamp = cyc + 1;
    e.hs = hs; e.vs = vs; e.de = de;
    e.chk = chk || !de;
    e.da = (de && hit(x, y, shadow, 1, 9, 9)) ? 24'hFF0000 : data;
    e.db = (de && hit(x, y, shadow, 0, 0, 0)) ? 24'hFF0000 : data;
    q.push_back(e);
    @(posedge pclk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    logic [26:0] a, b;
    a = {vif_a.o_hs, vif_a.o_vs, vif_a.o_de, vif_a.o_data};
    b = {vif_b.o_hs, vif_b.o_vs, vif_b.o_de, vif_b.o_data};
    checks++;
    if (a != '0 || b != '0) begin
      errors++;
      $display("FAIL %s got a=%h b=%h want 0", name, a, b);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    prev_vs_tb = 1'b0;
    shadow = '0;
    #2;
    chk_zero("rst_async");
    @(posedge pclk);
    #1;
    chk_zero("rst_hold");
    rst_n = 1'b1;
  endtask

  task automatic frame(input logic [23:0] t0, input int chg_line, input logic [23:0] t1,
                       input int rst_line, input int rst_pix);
    bit post_rst;
    logic hs, vs, de;
    logic [23:0] data;
    post_rst = 1'b0;
    for (int l = 0; l < V_TOT; l++) begin
      for (int p = 0; p < H_TOT; p++) begin
        if (l == 0 && p == 0) rtc = t0;
        if (l == chg_line && p == 0) rtc = t1;
        if (l == rst_line && p == rst_pix) begin
          do_reset();
          post_rst = 1'b1;
        end
        vs = (l == 0);
        de = (l >= 2) && (p < H_ACT);
        hs = (p >= 142) && (p < 146);
        data = de ? bars[p / 18] : (24'((l << 8) | p) ^ 24'h5A5A5A);
        pix(hs, vs, de, data, p, l - 2, !post_rst);
      end
    end
    frame_no++;
    $display("frame %0d rtc_start=%h rtc_end=%h reset=%0d", frame_no, t0, rtc, post_rst);
  endtask

  // Scoreboard monitor: output after edge n belongs to the pixel sampled at n-1.
  always @(negedge pclk) begin
    while (q.size() > 0 && q[0].stamp < cyc - 1) begin
      errors++;
      checks++;
      $display("FAIL stale stamp=%0d now=%0d", q[0].stamp, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].stamp == cyc - 1) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({vif_a.o_hs, vif_a.o_vs, vif_a.o_de} != {e.hs, e.vs, e.de} ||
          {vif_b.o_hs, vif_b.o_vs, vif_b.o_de} != {e.hs, e.vs, e.de}) begin
        errors++;
        $display("FAIL sync stamp=%0d got a=%b%b%b b=%b%b%b want %b%b%b", e.stamp,
                 vif_a.o_hs, vif_a.o_vs, vif_a.o_de, vif_b.o_hs, vif_b.o_vs, vif_b.o_de,
                 e.hs, e.vs, e.de);
      end
      if (e.chk) begin
        checks++;
        if (vif_a.o_data != e.da) begin
          errors++;
          $display("FAIL data_a stamp=%0d got %h want %h", e.stamp, vif_a.o_data, e.da);
        end
        checks++;
        if (vif_b.o_data != e.db) begin
          errors++;
          $display("FAIL data_b stamp=%0d got %h want %h", e.stamp, vif_b.o_data, e.db);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    font_tb[0]  = 128'h00007cc6c6cedef6e6c6c67c00000000;
    font_tb[1]  = 128'h00001838781818181818187e00000000;
    font_tb[2]  = 128'h00007cc6060c183060c0c6fe00000000;
    font_tb[3]  = 128'h00007cc606063c060606c67c00000000;
    font_tb[4]  = 128'h00000c1c3c6cccfe0c0c0c1e00000000;
    font_tb[5]  = 128'h0000fec0c0c0fc060606c67c00000000;
    font_tb[6]  = 128'h00003860c0c0fcc6c6c6c67c00000000;
    font_tb[7]  = 128'h0000fec606060c183030303000000000;
    font_tb[8]  = 128'h00007cc6c6c67cc6c6c6c67c00000000;
    font_tb[9]  = 128'h00007cc6c6c67e0606060c7800000000;
    font_tb[10] = 128'h00000000181800000018180000000000;
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'h808080; bars[6] = 24'h0000FF; bars[7] = 24'h000000;

    vif_a.i_hs = 1'b0; vif_a.i_vs = 1'b0; vif_a.i_de = 1'b0; vif_a.i_data = '0;
    vif_b.i_hs = 1'b0; vif_b.i_vs = 1'b0; vif_b.i_de = 1'b0; vif_b.i_data = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk_zero("reset_state");
    rst_n = 1'b1;

    frame(24'h131001, -1, 24'h0, -1, 0);
    frame(24'h131001, -1, 24'h0, -1, 0);
    frame(24'h235959, 20, 24'h000000, -1, 0);
    frame(24'h000000, -1, 24'h0, -1, 0);
    frame(24'h1A0F05, -1, 24'h0, -1, 0);
    frame(24'h131001, -1, 24'h0, 15, 40);
    frame(24'h131001, -1, 24'h0, -1, 0);

    for (int i = 0; i < 600; i++) begin
      pix(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          24'($urandom), 0, 0, 1'b0);
    end
    for (int i = 0; i < 4; i++) pix(1'b0, 1'b0, 1'b0, 24'h0, 0, 0, 1'b1);
    $display("random sync segment done");

    repeat (4) @(posedge pclk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
